spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 166 ++++++++++++++++
 tb/tb_spi_slave.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave: MSB-first frames of WIDTH bits, with the raw SPI pins
// synchronised into the global_clk domain. A one-entry holding buffer feeds
// the transmit shifter, and rx_valid pulses once for each completed frame.
module spi_slave #(
    parameter int WIDTH = 8
) (
    input  logic             global_clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Bit 0 is the first synchroniser stage; bit 2 is the edge-detect history.
    logic [2:0]       r_sclk_sync;
    logic [2:0]       r_ss_sync;
    logic [1:0]       r_mosi_sync;

    logic [CW-1:0]    r_cnt;
    logic             r_reload;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_buf;
    logic             r_buf_full;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;

    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_ss_rise;
    logic             w_ss_fall;
    logic             w_start;
    logic             w_end;
    logic             w_sh_rise;
    logic             w_sh_fall;
    logic             w_load;
    logic             w_wrap;
    logic [WIDTH-1:0] w_rx_next;
    logic [WIDTH-1:0] w_buf_out;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
    assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];

    // A rising ss wins over any sclk edge seen in the same cycle.
    assign w_start   = (r_state == IDLE) & w_ss_fall;
    assign w_end     = (r_state == ACTIVE) & w_ss_rise;
    assign w_sh_rise = (r_state == ACTIVE) & ~w_ss_rise & w_sclk_rise;
    assign w_sh_fall = (r_state == ACTIVE) & ~w_ss_rise & w_sclk_fall;

    // The shifter reloads at frame start and on the first falling edge after a wrap.
    assign w_load    = w_start | (w_sh_fall & r_reload);
    assign w_wrap    = w_sh_rise & (r_cnt == CW'(WIDTH - 1));
    assign w_rx_next = {r_rx_shift[WIDTH-2:0], r_mosi_sync[1]};
    assign w_buf_out = r_buf_full ? r_buf : '0;

    assign miso     = (r_state == ACTIVE) & r_tx_shift[WIDTH-1];
    assign busy     = (r_state == ACTIVE);
    assign tx_ready = ~r_buf_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    // Bring the asynchronous SPI pins into the global_clk domain.
    always_ff @(posedge global_clk) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_ss_sync   <= {r_ss_sync[1:0], ss};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    // State register.
    always_ff @(posedge global_clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: ss falling opens a transfer, ss rising closes it from any bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_state_nxt = ACTIVE;
            ACTIVE:  if (w_ss_rise) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Receive path and bit counter; a partial frame is simply forgotten on ss rise.
    always_ff @(posedge global_clk) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_reload   <= 1'b0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_start || w_end) begin
                r_cnt    <= '0;
                r_reload <= 1'b0;
            end else if (w_sh_rise) begin
                r_rx_shift <= w_rx_next;
                if (w_wrap) begin
                    r_cnt      <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_reload   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (w_sh_fall) begin
                r_reload <= 1'b0;
            end
        end
    end

    // Transmit shifter: load a fresh word or shift out the next MSB.
    always_ff @(posedge global_clk) begin
        if (!reset) begin
            r_tx_shift <= '0;
        end else if (w_load) begin
            r_tx_shift <= w_buf_out;
        end else if (w_sh_fall) begin
            r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
        end
    end

    // Holding buffer: a write always wins, even when the shifter takes the old word.
    always_ff @(posedge global_clk) begin
        if (!reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (tx_load) begin
            r_buf      <= tx_data;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a transaction-level model replays each raw sclk/ss
// transition three clock edges later and predicts every output on every cycle.
module tb_spi_slave;

    localparam int W = 8;
    localparam int EV_SS_FALL   = 0;
    localparam int EV_SS_RISE   = 1;
    localparam int EV_SCLK_RISE = 2;
    localparam int EV_SCLK_FALL = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sclk_r = 1'b0;
    logic         ss_r = 1'b1;
    logic         mosi_r = 1'b0;
    logic         tx_load = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         miso;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;

    spi_slave #(.WIDTH(W)) dut (
        .global_clk (clk),
        .reset      (rst_n),
        .sclk       (sclk_r),
        .ss         (ss_r),
        .mosi       (mosi_r),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   due;
        int   kind;
        logic b;
    } ev_t;

    ev_t          evq[$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int           vld_cnt = 0;
    int           half = 4;

    // Model state
    bit           m_active = 1'b0;
    logic [W-1:0] m_buf = '0;
    bit           m_full = 1'b0;
    logic         m_txq[$];
    logic         m_rxq[$];
    logic [W-1:0] m_rx = '0;
    int           m_vld_cyc = -10;
    bit           m_reload = 1'b0;
    ev_t          m_ev;
    logic         m_miso;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic void m_load();
        m_txq.delete();
        for (int i = W - 1; i >= 0; i--) m_txq.push_back(m_full ? m_buf[i] : 1'b0);
        m_full = 1'b0;
    endfunction

    task automatic apply_ev(input ev_t e);
        case (e.kind)
            EV_SS_FALL: if (!m_active) begin
                m_active = 1'b1;
                m_load();
                m_rxq.delete();
                m_reload = 1'b0;
            end
            EV_SS_RISE: if (m_active) begin
                m_active = 1'b0;
                m_rxq.delete();
                m_reload = 1'b0;
            end
            EV_SCLK_RISE: if (m_active) begin
                m_rxq.push_back(e.b);
                if (m_rxq.size() == W) begin
                    for (int i = 0; i < W; i++) m_rx[W-1-i] = m_rxq[i];
                    m_vld_cyc = cyc;
                    m_rxq.delete();
                    m_reload = 1'b1;
                end
            end
            EV_SCLK_FALL: if (m_active) begin
                if (m_reload) begin
                    m_load();
                    m_reload = 1'b0;
                end else if (m_txq.size() > 0) begin
                    void'(m_txq.pop_front());
                end
            end
            default: ;
        endcase
    endtask

    // Model update and per-cycle comparison, just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            m_active = 1'b0;
            m_full   = 1'b0;
            m_buf    = '0;
            m_txq.delete();
            m_rxq.delete();
            m_rx     = '0;
            m_reload = 1'b0;
            evq.delete();
        end else begin
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                m_ev = evq.pop_front();
                apply_ev(m_ev);
            end
            if (tx_load) begin
                m_buf  = tx_data;
                m_full = 1'b1;
            end
        end
        if (rx_valid === 1'b1) vld_cnt++;
        m_miso = (m_active && m_txq.size() > 0) ? m_txq[0] : 1'b0;
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("miso", {31'd0, miso}, {31'd0, m_miso});
        chk("tx_ready", {31'd0, tx_ready}, {31'd0, !m_full});
        chk("rx_data", {24'd0, rx_data}, {24'd0, m_rx});
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, (cyc == m_vld_cyc)});
    end

    task automatic nclk(input int n);
        repeat (n) begin
            @(negedge clk);
            tx_load = 1'b0;
        end
    endtask

    task automatic set_ss(input logic v);
        ev_t e;
        if (ss_r !== v) begin
            e.due  = cyc + 3;
            e.kind = v ? EV_SS_RISE : EV_SS_FALL;
            e.b    = 1'b0;
            evq.push_back(e);
        end
        ss_r = v;
    endtask

    task automatic set_sclk(input logic v);
        ev_t e;
        if (sclk_r !== v) begin
            e.due  = cyc + 3;
            e.kind = v ? EV_SCLK_RISE : EV_SCLK_FALL;
            e.b    = mosi_r;
            evq.push_back(e);
        end
        sclk_r = v;
    endtask

    // Master side: clock out nbits of mo, capture miso before each rising edge.
    task automatic spi_bits(input logic [W-1:0] mo, input int nbits, input int load_at,
                            input logic [W-1:0] ld, output logic [W-1:0] mi,
                            output logic rdy_mid);
        mi = '0;
        rdy_mid = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            mosi_r = mo[W-1-i];
            if (i == load_at) begin
                tx_load = 1'b1;
                tx_data = ld;
            end
            nclk(half);
            mi = {mi[W-2:0], miso};
            if (i == nbits - 1) rdy_mid = tx_ready;
            set_sclk(1'b1);
            nclk(half);
            set_sclk(1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] mi;
        logic [W-1:0] mi2;
        logic         rdy;
        int           v0;
        int           nf;
        int           nb;
        int           la;
        logic [31:0]  r1;
        logic [31:0]  r2;

        nclk(3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        rst_n = 1'b1;
        nclk(4);

        // Single frame: slave sends A5 while receiving 3C.
        tx_load = 1'b1;
        tx_data = 8'hA5;
        nclk(2);
        chk("t1_ready_loaded", {31'd0, tx_ready}, 32'd0);
        v0 = vld_cnt;
        set_ss(1'b0);
        nclk(half + 1);
        chk("t1_ready_after_ss", {31'd0, tx_ready}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        spi_bits(8'h3C, 8, -1, 8'h00, mi, rdy);
        chk("t1_miso_bits", {24'd0, mi}, 32'hA5);
        nclk(half);
        set_ss(1'b1);
        nclk(half);
        chk("t1_rx_data", {24'd0, rx_data}, 32'h3C);
        chk("t1_pulses", v0 == vld_cnt - 1, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // Back-to-back frames 11 then EE; 5A loaded during the first one.
        v0 = vld_cnt;
        set_ss(1'b0);
        nclk(half);
        spi_bits(8'h11, 8, 3, 8'h5A, mi, rdy);
        chk("t2_miso1", {24'd0, mi}, 32'h00);
        chk("t2_rx1", {24'd0, rx_data}, 32'h11);
        spi_bits(8'hEE, 8, -1, 8'h00, mi2, rdy);
        chk("t2_miso2", {24'd0, mi2}, 32'h5A);
        nclk(half);
        set_ss(1'b1);
        nclk(half);
        chk("t2_rx2", {24'd0, rx_data}, 32'hEE);
        chk("t2_pulses", vld_cnt - v0, 32'd2);

        // Aborted 5-bit frame, then a full 81 frame.
        v0 = vld_cnt;
        set_ss(1'b0);
        nclk(half);
        spi_bits(8'hF0, 5, -1, 8'h00, mi, rdy);
        nclk(half);
        set_ss(1'b1);
        nclk(half);
        chk("t3_rx_kept", {24'd0, rx_data}, 32'hEE);
        chk("t3_no_pulse", vld_cnt - v0, 32'd0);
        set_ss(1'b0);
        nclk(half);
        spi_bits(8'h81, 8, -1, 8'h00, mi, rdy);
        nclk(half);
        set_ss(1'b1);
        nclk(half);
        chk("t3_rx_81", {24'd0, rx_data}, 32'h81);
        chk("t3_one_pulse", vld_cnt - v0, 32'd1);

        // Empty buffer sends zeros; a mid-frame load holds until the wrap reload.
        set_ss(1'b0);
        nclk(half);
        spi_bits(8'h42, 8, -1, 8'h00, mi, rdy);
        chk("t4_miso_zero", {24'd0, mi}, 32'h00);
        spi_bits(8'h24, 8, 2, 8'h77, mi, rdy);
        chk("t4_miso_zero2", {24'd0, mi}, 32'h00);
        chk("t4_ready_mid", {31'd0, rdy}, 32'd0);
        nclk(half);
        set_ss(1'b1);
        nclk(half);
        chk("t4_ready_after", {31'd0, tx_ready}, 32'd1);

        // Reset after four bits, released with ss still low.
        set_ss(1'b0);
        nclk(half);
        tx_load = 1'b1;
        tx_data = 8'h99;
        nclk(1);
        spi_bits(8'hC3, 4, -1, 8'h00, mi, rdy);
        nclk(half);
        chk("t5_ready_pre", {31'd0, tx_ready}, 32'd0);
        rst_n = 1'b0;
        nclk(3);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_miso", {31'd0, miso}, 32'd0);
        chk("t5_ready", {31'd0, tx_ready}, 32'd1);
        chk("t5_rx_data", {24'd0, rx_data}, 32'd0);
        chk("t5_rx_valid", {31'd0, rx_valid}, 32'd0);
        rst_n = 1'b1;
        v0 = vld_cnt;
        spi_bits(8'hFF, 8, -1, 8'h00, mi, rdy);
        nclk(half);
        chk("t5_ignored_busy", {31'd0, busy}, 32'd0);
        chk("t5_ignored_pulse", vld_cnt - v0, 32'd0);
        chk("t5_ignored_rx", {24'd0, rx_data}, 32'd0);
        set_ss(1'b1);
        nclk(half);
        set_ss(1'b0);
        nclk(half);
        spi_bits(8'h5C, 8, -1, 8'h00, mi, rdy);
        nclk(half);
        set_ss(1'b1);
        nclk(half);
        chk("t5_rx_after", {24'd0, rx_data}, 32'h5C);

        // Load coinciding with the ss-fall load: old word goes out, new one is held.
        tx_load = 1'b1;
        tx_data = 8'h3A;
        nclk(1);
        set_ss(1'b0);
        nclk(2);
        tx_load = 1'b1;
        tx_data = 8'hC5;
        nclk(1);
        nclk(half);
        chk("t6_ready_held", {31'd0, tx_ready}, 32'd0);
        spi_bits(8'h0F, 8, -1, 8'h00, mi, rdy);
        chk("t6_miso_old", {24'd0, mi}, 32'h3A);
        chk("t6_ready_mid", {31'd0, rdy}, 32'd0);
        spi_bits(8'hF0, 8, -1, 8'h00, mi2, rdy);
        chk("t6_miso_new", {24'd0, mi2}, 32'hC5);
        nclk(half);
        set_ss(1'b1);
        nclk(half);

        // Randomised transfers checked by the per-cycle model.
        for (int it = 0; it < 40; it++) begin
            half = $urandom_range(4, 6);
            if ($urandom_range(0, 1) == 1) begin
                r1 = $urandom;
                tx_load = 1'b1;
                tx_data = r1[W-1:0];
                nclk(1);
            end
            set_ss(1'b0);
            nclk(half);
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
                la = $urandom_range(0, 9);
                if (la > 7) la = -1;
                r1 = $urandom;
                r2 = $urandom;
                spi_bits(r1[W-1:0], nb, la, r2[W-1:0], mi, rdy);
                if (nb != 8) break;
            end
            nclk(half);
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0;
                nclk(2);
                rst_n = 1'b1;
                nclk(1);
            end
            set_ss(1'b1);
            nclk($urandom_range(half, 3 * half));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
